// File: rtl/fourbyte_pkg.sv
// Shared types and default sizes for the 4-byte memory FIFO controller.
package fourbyte_pkg;

   localparam int unsigned DW_DEF    = 8;
   localparam int unsigned AW_DEF    = 2;
   localparam int unsigned DEPTH_DEF = 2 ** AW_DEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD1  = 2'd1,
      RD2  = 2'd2
   } state_t;

endpackage

// File: rtl/fourbyte_fifo_ctrl.sv
// Valid/ready FIFO controller in front of a single-port 4x8 memory array,
// with a one-byte output register holding the head byte.
module fourbyte_fifo_ctrl
   import fourbyte_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_valid,
   output logic          push_ready,
   input  logic [DW-1:0] push_data,
   output logic          pop_valid,
   input  logic          pop_ready,
   output logic [DW-1:0] pop_data,
   output logic [AW:0]   count,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty,
   output logic          mem_en,
   output logic          mem_wr,
   output logic [0:AW-1] mem_adr,
   output logic [DW-1:0] mem_data,
   input  logic [DW-1:0] mem_out
);

   localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_push;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign level = count + {{AW{1'b0}}, pop_valid};

   // Next-state, handshake and memory port drive; everything idles under reset.
   always_comb begin
      state_nxt  = state;
      push_ready = 1'b0;
      do_push    = 1'b0;
      mem_en     = 1'b0;
      mem_wr     = 1'b0;
      mem_adr    = '0;
      mem_data   = '0;
      if (rst_n) begin
         case (state)
            IDLE: begin
               if (!pop_valid && (count != '0)) begin
                  state_nxt = RD1;
               end else begin
                  push_ready = (count != FULL_CNT);
                  if (push_valid && (count != FULL_CNT)) begin
                     do_push  = 1'b1;
                     mem_en   = 1'b1;
                     mem_wr   = 1'b1;
                     mem_adr  = wptr;
                     mem_data = push_data;
                  end
               end
            end
            RD1: begin
               mem_en    = 1'b1;
               mem_adr   = rptr;
               state_nxt = RD2;
            end
            RD2: begin
               mem_en    = 1'b1;
               mem_adr   = rptr;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State, pointers, occupancy and output register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         pop_valid <= 1'b0;
         pop_data  <= '0;
      end else begin
         state <= state_nxt;
         if (do_push) begin
            wptr  <= wptr + 1'b1;
            count <= count + 1'b1;
         end
         // Capture and pop are exclusive: a read only starts with pop_valid low.
         if (state == RD2) begin
            pop_data  <= mem_out;
            pop_valid <= 1'b1;
            rptr      <= rptr + 1'b1;
            count     <= count - 1'b1;
         end else if (pop_valid && pop_ready) begin
            pop_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/fourbyte_fifo_ctrl.md
Name: fourbyte_fifo_ctrl

Overview:
- FIFO controller that sits directly upstream of the 4-byte memory array.
- Drives the array's en/wr/adr/data inputs and consumes its out bus, turning the single-port 4×8 store into a 4-deep valid/ready FIFO.
- Adds a 1-entry output register, so total capacity is 5 bytes.
- One memory access per cycle, no bypass path.

Parameters:
- DW, 8, data width (matches the memory byte).
- AW, 2, memory address width; DEPTH = 2**AW = 4.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- push_valid  in  1  upstream has a byte.
- push_ready  out  1  controller accepts the byte this cycle.
- push_data  in  DW  byte to store.
- pop_valid  out  1  pop_data holds a valid byte.
- pop_ready  in  1  downstream takes the byte.
- pop_data  out  DW  head-of-FIFO byte.
- count  out  AW+1  bytes held in memory (0..DEPTH).
- level  out  AW+1  count + pop_valid (0..DEPTH+1).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- mem_en  out  1  memory enable.
- mem_wr  out  1  1 = write, 0 = read.
- mem_adr  out  AW  memory address, bit order [0:AW-1] with bit 0 as MSB, as on the memory port.
- mem_data  out  DW  write data to memory.
- mem_out  in  DW  read data from memory.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge):
  - state=IDLE; wptr=rptr=0; count=0; pop_valid=0; pop_data=0.
  - While rst_n=0: push_ready=0 and mem_en=0, combinationally.
- Reset mid-read: the read is aborted and pointers clear. Bytes stay in the array but are discarded.
- FSM states: IDLE, RD1, RD2.
- IDLE, read needed (pop_valid==0 && count>0):
  - Next state RD1.
  - push_ready=0; mem_en=0 this cycle.
- IDLE, otherwise:
  - push_ready = (count<DEPTH).
  - On push_valid&&push_ready: combinationally mem_en=1, mem_wr=1, mem_adr=wptr, mem_data=push_data.
  - The array commits the write at that edge; wptr+1 (mod DEPTH); count+1.
- RD1:
  - mem_en=1, mem_wr=0, mem_adr=rptr; push_ready=0.
  - Next state RD2.
- RD2:
  - Same memory drive as RD1; push_ready=0.
  - At the edge ending RD2: pop_data<=mem_out; pop_valid<=1; rptr+1 (mod DEPTH); count-1; next state IDLE.
- Memory outputs idle value: whenever not writing or in RD1/RD2, mem_en=0, mem_wr=0, mem_adr=0, mem_data=0.
- Pop:
  - pop_valid&&pop_ready at an edge clears pop_valid. Legal in any state.
  - A read is only started when pop_valid==0, so capture and pop never collide.
- Latency:
  - Push accepted in cycle 0 into an empty FIFO: IDLE decides in cycle 1, RD1 in cycle 2, RD2 in cycle 3, pop_valid=1 from cycle 4.
  - Back-to-back pops with memory non-empty: one byte per 4 cycles (pop edge, then IDLE, RD1, RD2).
- Simultaneous events:
  - Push and count decrement cannot coincide (push only in IDLE, decrement only in RD2).
  - A pop may coincide with a push or with the RD2 capture edge only if pop_valid was 1, which cannot happen in RD2.
- Boundaries:
  - full: push_ready=0 and wptr holds.
  - count==0 && pop_valid==0: FSM stays in IDLE, pop_valid=0.
  - Pointers wrap 3->0.
  - pop_data holds its last value while pop_valid=0.
- Width rules: pointers are AW bits and wrap naturally. count and level are AW+1 bits and never exceed DEPTH+1.
- push_valid/pop_ready may toggle freely. There is no requirement that valid stays high until ready.

Decomposition:
- Shared package fourbyte_pkg: state enum {IDLE, RD1, RD2}, DW/AW defaults, DEPTH constant.
- No sub-module needed. Pointers, count, FSM and output register live in one module.
- The bench instantiates the controller together with the existing 4-byte memory.

Test Plan:
- Reset with push_valid=1: push_ready=0, mem_en=0, count=0, pop_valid=0. After release, push 0xA5 at cycle 0: write to adr 0, pop_valid=1 at cycle 4 with pop_data=0xA5.
- Fill: push 0x11,0x22,0x33,0x44,0x55 with pop_ready=0. Required: level=5, count=4, full=1, push_ready=0. A 6th push is refused and 0x66 never reaches mem_data.
- Drain the fill case with pop_ready=1: pops in order 11,22,33,44,55; level steps 5->0; empty=1 at end; FSM idles.
- Wrap: 6 push/pop pairs interleaved. Addresses cycle 0,1,2,3,0,1; data returns in order with no duplication.
- Push held during RD1/RD2: push_ready=0 in both states; push accepted on return to IDLE; count increments once.
- Reset asserted in RD2: no capture, pop_valid stays 0, count=0, rptr=wptr=0; a subsequent push of 0x3C reads back 0x3C.
